// File: rtl/serial_word_tx_if.sv
`default_nettype none
// ------------------------------------------------------------------
// serial_word_tx_if : word handshake in, serial bit stream out
// Revision: 1.0
// ------------------------------------------------------------------
interface serial_word_tx_if #(
  parameter int LEN = 8
) ();
  logic [LEN-1:0] in_data;
  logic           in_valid;
  logic           in_ready;
  logic           sdo;
  logic           sen_n;
  logic           word_done;
  logic           busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, sdo, sen_n, word_done, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, sdo, sen_n, word_done, busy
  );
endinterface
`default_nettype wire

// File: rtl/serial_word_tx.sv
`default_nettype none
// ------------------------------------------------------------------
// serial_word_tx : parallel word to serial bit line, one-word holding register
// Revision: 1.0
// ------------------------------------------------------------------
module serial_word_tx #(
  parameter int LEN       = 8,
  parameter int MSB_FIRST = 1,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             rst,
  serial_word_tx_if.slave  bus
);
  localparam int              CW     = $clog2(LEN);
  localparam int              C_SBIT = (MSB_FIRST != 0) ? LEN - 1 : 0;
  localparam logic [CW-1:0]   C_LAST = CW'(LEN - 1);
  localparam logic [3:0]      C_GAP  = 4'(GAP);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [LEN-1:0]  r_hold;
  logic            r_hold_full;
  logic [LEN-1:0]  r_shreg;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_gap_cnt;
  logic            w_load;
  logic            w_start_gap;
  logic            w_last;

  assign w_last = (r_state == ST_SHIFT) && (r_cnt == C_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_start_gap = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_hold_full) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_last) begin
          if (GAP > 0) begin
            w_start_gap = 1'b1;
            w_state_nxt = ST_GAP;
          end else if (r_hold_full) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (r_gap_cnt <= 4'd1) begin
          if (r_hold_full) begin
            w_load      = 1'b1;
            w_state_nxt = ST_SHIFT;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A reload empties the holding register, so in_ready is still low at that
  // edge and an accept can never coincide with a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_gap_cnt   <= 4'd0;
    end else begin
      if (w_load) begin
        r_shreg     <= r_hold;
        r_cnt       <= '0;
        r_hold_full <= 1'b0;
      end else begin
        if (r_state == ST_SHIFT) begin
          if (MSB_FIRST != 0) begin
            r_shreg <= {r_shreg[LEN-2:0], 1'b0};
          end else begin
            r_shreg <= {1'b0, r_shreg[LEN-1:1]};
          end
          r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        end
        if (bus.in_valid && !r_hold_full) begin
          r_hold      <= bus.in_data;
          r_hold_full <= 1'b1;
        end
      end
      if (w_start_gap) begin
        r_gap_cnt <= C_GAP;
      end else if (r_state == ST_GAP) begin
        r_gap_cnt <= r_gap_cnt - 4'd1;
      end
    end
  end

  // Serial outputs decode only state/shreg/cnt flops, never the in_* inputs.
  assign bus.in_ready  = !r_hold_full;
  assign bus.sen_n     = (r_state != ST_SHIFT);
  assign bus.sdo       = (r_state == ST_SHIFT) && r_shreg[C_SBIT];
  assign bus.word_done = w_last;
  assign bus.busy      = (r_state != ST_IDLE) || r_hold_full;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_tx.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_serial_word_tx : directed bench over three parameterisations
// Revision: 1.0
// ------------------------------------------------------------------
module tb_serial_word_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  int         sel       = 0;
  logic [7:0] drv_data  = 8'h00;
  logic       drv_valid = 1'b0;
  logic [7:0] words [4];

  logic m_ready, m_sdo, m_sen_n, m_wd, m_busy;
  logic rec_sen [64];
  logic rec_sdo [64];
  logic rec_wd  [64];
  logic rec_rdy [64];

  serial_word_tx_if #(.LEN(8)) if_a ();
  serial_word_tx_if #(.LEN(8)) if_b ();
  serial_word_tx_if #(.LEN(8)) if_c ();

  serial_word_tx #(.LEN(8), .MSB_FIRST(1), .GAP(0)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  serial_word_tx #(.LEN(8), .MSB_FIRST(1), .GAP(2)) u_b (.clk(clk), .rst(rst), .bus(if_b));
  serial_word_tx #(.LEN(8), .MSB_FIRST(0), .GAP(0)) u_c (.clk(clk), .rst(rst), .bus(if_c));

  assign if_a.in_data  = drv_data;
  assign if_b.in_data  = drv_data;
  assign if_c.in_data  = drv_data;
  assign if_a.in_valid = drv_valid && (sel == 0);
  assign if_b.in_valid = drv_valid && (sel == 1);
  assign if_c.in_valid = drv_valid && (sel == 2);

  always_comb begin
    m_ready = if_c.in_ready;
    m_sdo   = if_c.sdo;
    m_sen_n = if_c.sen_n;
    m_wd    = if_c.word_done;
    m_busy  = if_c.busy;
    if (sel == 0) begin
      m_ready = if_a.in_ready; m_sdo = if_a.sdo; m_sen_n = if_a.sen_n;
      m_wd    = if_a.word_done; m_busy = if_a.busy;
    end else if (sel == 1) begin
      m_ready = if_b.in_ready; m_sdo = if_b.sdo; m_sen_n = if_b.sen_n;
      m_wd    = if_b.word_done; m_busy = if_b.busy;
    end
  end

  always #5 clk = ~clk;

  // Offers words[0..n-1] in order, holding each until in_ready is seen.
  task automatic send(input int n);
    int guard;
    for (int w = 0; w < n; w++) begin
      drv_data  = words[w];
      drv_valid = 1'b1;
      guard     = 0;
      while (!m_ready && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 100) begin
        n_tests++; n_fail++;
        $display("FAIL send_timeout word %0d: in_ready=0, required 1", w);
      end
      @(negedge clk);
    end
    drv_valid = 1'b0;
  endtask

  task automatic record(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      rec_sen[j] = m_sen_n;
      rec_sdo[j] = m_sdo;
      rec_wd[j]  = m_wd;
      rec_rdy[j] = m_ready;
    end
  endtask

  task automatic test_reset();
    logic [4:0] act;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    act = {if_a.sdo, if_a.sen_n, if_a.word_done, if_a.busy, if_a.in_ready};
    n_tests++;
    if (act !== 5'b01001) begin
      n_fail++; $display("FAIL reset_a {sdo,sen_n,wd,busy,rdy}=%b expected 01001", act);
    end
    act = {if_b.sdo, if_b.sen_n, if_b.word_done, if_b.busy, if_b.in_ready};
    n_tests++;
    if (act !== 5'b01001) begin
      n_fail++; $display("FAIL reset_b {sdo,sen_n,wd,busy,rdy}=%b expected 01001", act);
    end
    act = {if_c.sdo, if_c.sen_n, if_c.word_done, if_c.busy, if_c.in_ready};
    n_tests++;
    if (act !== 5'b01001) begin
      n_fail++; $display("FAIL reset_c {sdo,sen_n,wd,busy,rdy}=%b expected 01001", act);
    end
  endtask

  task automatic test_single_msb();
    logic [7:0] w = 8'hA5;
    logic [2:0] act, exp;
    sel = 0; words[0] = w;
    repeat (4) @(negedge clk);
    fork send(1); record(10); join
    n_tests++;
    if (rec_rdy[0] !== 1'b0) begin
      n_fail++; $display("FAIL single_ready_j0 in_ready=%b expected 0", rec_rdy[0]);
    end
    for (int j = 0; j < 10; j++) begin
      exp = {1'b1, 1'b0, 1'b0};
      if (j >= 1 && j <= 8) exp = {1'b0, w[8-j], (j == 8)};
      act = {rec_sen[j], rec_sdo[j], rec_wd[j]};
      n_tests++;
      if (act !== exp) begin
        n_fail++; $display("FAIL single_msb cycle %0d {sen_n,sdo,wd}=%b expected %b", j, act, exp);
      end
    end
    n_tests++;
    if (m_busy !== 1'b0) begin
      n_fail++; $display("FAIL single_busy_end busy=%b expected 0", m_busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] bits = {8'hA5, 8'h3C};
    logic [2:0]  act, exp;
    sel = 0; words[0] = 8'hA5; words[1] = 8'h3C;
    repeat (4) @(negedge clk);
    fork send(2); record(20); join
    for (int j = 0; j < 20; j++) begin
      exp = 3'b100;
      if (j >= 1 && j <= 16) exp = {1'b0, bits[16-j], (j == 8 || j == 16)};
      act = {rec_sen[j], rec_sdo[j], rec_wd[j]};
      n_tests++;
      if (act !== exp) begin
        n_fail++; $display("FAIL back_to_back cycle %0d {sen_n,sdo,wd}=%b expected %b", j, act, exp);
      end
    end
  endtask

  task automatic test_gap();
    logic [7:0] w1 = 8'hA5;
    logic [7:0] w2 = 8'h3C;
    logic [2:0] act, exp;
    sel = 1; words[0] = w1; words[1] = w2;
    repeat (4) @(negedge clk);
    fork send(2); record(22); join
    for (int j = 0; j < 22; j++) begin
      exp = 3'b100;
      if (j >= 1 && j <= 8)   exp = {1'b0, w1[8-j],  (j == 8)};
      if (j >= 11 && j <= 18) exp = {1'b0, w2[18-j], (j == 18)};
      act = {rec_sen[j], rec_sdo[j], rec_wd[j]};
      n_tests++;
      if (act !== exp) begin
        n_fail++; $display("FAIL gap2 cycle %0d {sen_n,sdo,wd}=%b expected %b", j, act, exp);
      end
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] w = 8'h01;
    logic [2:0] act, exp;
    sel = 2; words[0] = w;
    repeat (4) @(negedge clk);
    fork send(1); record(10); join
    for (int j = 0; j < 10; j++) begin
      exp = 3'b100;
      if (j >= 1 && j <= 8) exp = {1'b0, w[j-1], (j == 8)};
      act = {rec_sen[j], rec_sdo[j], rec_wd[j]};
      n_tests++;
      if (act !== exp) begin
        n_fail++; $display("FAIL lsb_first cycle %0d {sen_n,sdo,wd}=%b expected %b", j, act, exp);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] bits = {8'hC3, 8'h5A, 8'hF0};
    logic [3:0]  act, exp;
    logic        exp_rdy;
    sel = 0; words[0] = 8'hC3; words[1] = 8'h5A; words[2] = 8'hF0;
    repeat (4) @(negedge clk);
    fork send(3); record(28); join
    for (int j = 0; j < 28; j++) begin
      exp_rdy = (j == 1) || (j == 9) || (j >= 17);
      exp = {exp_rdy, 3'b100};
      if (j >= 1 && j <= 24) exp = {exp_rdy, 1'b0, bits[24-j], (j % 8 == 0)};
      act = {rec_rdy[j], rec_sen[j], rec_sdo[j], rec_wd[j]};
      n_tests++;
      if (act !== exp) begin
        n_fail++; $display("FAIL backpressure cycle %0d {rdy,sen_n,sdo,wd}=%b expected %b", j, act, exp);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    logic [4:0] act;
    int         bad;
    sel = 0; words[0] = 8'hFF; words[1] = 8'h81;
    repeat (4) @(negedge clk);
    fork send(2); record(4); join
    for (int j = 1; j < 4; j++) begin
      n_tests++;
      if ({rec_sen[j], rec_sdo[j]} !== 2'b01) begin
        n_fail++; $display("FAIL midreset_bit%0d {sen_n,sdo}=%b expected 01", j, {rec_sen[j], rec_sdo[j]});
      end
    end
    rst = 1'b1;
    @(negedge clk);
    act = {m_sdo, m_sen_n, m_wd, m_busy, m_ready};
    n_tests++;
    if (act !== 5'b01001) begin
      n_fail++; $display("FAIL midreset_after {sdo,sen_n,wd,busy,rdy}=%b expected 01001", act);
    end
    rst = 1'b0;
    bad = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (m_sen_n !== 1'b1 || m_wd !== 1'b0 || m_sdo !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL midreset_quiet active cycles=%0d expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_single_msb();
    test_back_to_back();
    test_gap();
    test_lsb_first();
    test_backpressure();
    test_reset_mid_word();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1);
  end
endmodule
`default_nettype wire
